// File: rtl/sram_rw_arbiter_if.sv
// Bundles the read/write requester handshakes and the RW0 SRAM macro pins of sram_rw_arbiter.
// The slave modport is the arbiter's view; master is the requester/macro side.
interface sram_rw_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 53
);
  logic          r_req_valid;
  logic          r_req_ready;
  logic [AW-1:0] r_req_addr;
  logic          r_resp_valid;
  logic [DW-1:0] r_resp_data;
  logic          w_req_valid;
  logic          w_req_ready;
  logic [AW-1:0] w_req_addr;
  logic [DW-1:0] w_req_data;
  logic          init_done;
  logic          sram_en;
  logic          sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  modport slave (
    input  r_req_valid, r_req_addr, w_req_valid, w_req_addr, w_req_data, sram_rdata,
    output r_req_ready, r_resp_valid, r_resp_data, w_req_ready, init_done,
           sram_en, sram_wmode, sram_addr, sram_wdata
  );

  modport master (
    output r_req_valid, r_req_addr, w_req_valid, w_req_addr, w_req_data, sram_rdata,
    input  r_req_ready, r_resp_valid, r_resp_data, w_req_ready, init_done,
           sram_en, sram_wmode, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_rw_arbiter.sv
// Shares one single-port SRAM between a read requester (priority) and a buffered write
// requester; zero-fills the array after reset and bypasses reads that hit the write buffer.
module sram_rw_arbiter #(
  parameter int DEPTH      = 128,
  parameter int DW         = 53,
  parameter int WBUF_DEPTH = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  sram_rw_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WBUF_DEPTH + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wb_addr_q [WBUF_DEPTH];
  logic [AW-1:0] wb_addr_d [WBUF_DEPTH];
  logic [DW-1:0] wb_data_q [WBUF_DEPTH];
  logic [DW-1:0] wb_data_d [WBUF_DEPTH];
  logic          resp_valid_q, resp_valid_d;
  logic          hit_q, hit_d;
  logic [DW-1:0] hit_data_q, hit_data_d;
  logic [DW-1:0] resp_hold_q, resp_hold_d;
  logic [DW-1:0] resp_data;
  logic [CW-1:0] wr_idx;
  logic          run, full, drain, rd_fire, wr_fire;

  always_comb begin
    run     = (state_q == ST_RUN);
    full    = (count_q == CW'(WBUF_DEPTH));
    rd_fire = run && !full && bus.r_req_valid;
    wr_fire = run && !full && bus.w_req_valid;
    drain   = run && (full || (!bus.r_req_valid && (count_q != '0)));
  end

  // SRAM port: a full buffer wins over reads so a read stream cannot starve writes.
  // During INIT the enable is gated by reset_n so the macro stays quiet while in reset.
  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (state_q == ST_INIT) begin
      bus.sram_en    = reset_n;
      bus.sram_wmode = reset_n;
      bus.sram_addr  = cnt_q;
    end else if (drain) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = wb_addr_q[0];
      bus.sram_wdata = wb_data_q[0];
    end else if (rd_fire) begin
      bus.sram_en    = 1'b1;
      bus.sram_addr  = bus.r_req_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  // Higher buffer index is younger, so the last match in the scan wins.
  always_comb begin
    hit_d      = 1'b0;
    hit_data_d = hit_data_q;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ((CW'(i) < count_q) && (wb_addr_q[i] == bus.r_req_addr)) begin
        hit_d      = rd_fire;
        hit_data_d = wb_data_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      wb_addr_d[i] = wb_addr_q[i];
      wb_data_d[i] = wb_data_q[i];
    end
    if (drain) begin
      for (int i = 0; i < WBUF_DEPTH - 1; i++) begin
        wb_addr_d[i] = wb_addr_q[i + 1];
        wb_data_d[i] = wb_data_q[i + 1];
      end
    end
    wr_idx = count_q - CW'(drain);
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (wr_fire && (CW'(i) == wr_idx)) begin
        wb_addr_d[i] = bus.w_req_addr;
        wb_data_d[i] = bus.w_req_data;
      end
    end
    count_d = count_q + CW'(wr_fire) - CW'(drain);
  end

  always_comb begin
    resp_valid_d = rd_fire;
    resp_data    = resp_valid_q ? (hit_q ? hit_data_q : bus.sram_rdata) : resp_hold_q;
    resp_hold_d  = resp_data;
  end

  assign bus.r_resp_valid = resp_valid_q;
  assign bus.r_resp_data  = resp_data;
  assign bus.r_req_ready  = run && !full;
  assign bus.w_req_ready  = run && !full;
  assign bus.init_done    = run;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      count_q      <= '0;
      resp_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      hit_data_q   <= '0;
      resp_hold_q  <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      hit_q        <= hit_d;
      hit_data_q   <= hit_data_d;
      resp_hold_q  <= resp_hold_d;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr_q[i] <= wb_addr_d[i];
        wb_data_q[i] <= wb_data_d[i];
      end
    end
  end
endmodule
